// File: rtl/hack_mem_pkg.sv
// Purpose: Hack data-memory map constants and region type, shared by the cpu top, this controller and the display writer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hack_mem_pkg;

   localparam logic [14:0] SCREEN_BASE = 15'h4000;
   localparam logic [14:0] KBD_ADDR    = 15'h6000;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_SCREEN,
      REG_KBD,
      REG_NONE
   } region_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with a show-ahead head (dout is the oldest entry, 0 when empty).
// Latency: a push is visible on dout/!empty one cycle later; there is no same-cycle bypass.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle, otherwise it is dropped and flagged.
//
// Ports: clk, reset (sync, active-high), push/din, pop, dout, empty, full,
//        overflow_pulse (one cycle, a push was dropped).
module sync_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             overflow_pulse
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the slot this push needs, so full alone does not drop.
   assign do_push = push && (!full || do_pop);
   assign overflow_pulse = push && !do_push;

   // Mask the head while empty so the output is defined (zero) out of reset.
   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/data_memory_controller.sv
// Purpose: CPU data-memory responder decoding the Hack map (data RAM, screen RAM, keyboard) and queueing screen writes.
// Latency: reads return on inM one cycle after addressM is sampled; screen events appear on fb_* one cycle after the write.
// Backpressure: fb_valid/fb_ready handshake; when the event queue is full and not popping, the event is dropped and fifo_overflow sticks.
//
// Ports: clk, reset (sync, active-high); CPU side addressM/outM/writeM -> inM;
//        keyboard key_valid/key_code; framebuffer fb_valid/fb_ready/fb_addr/fb_data;
//        fifo_overflow (sticky until reset).
module data_memory_controller #(
   parameter int RAM_WORDS    = 16384,
   parameter int SCREEN_WORDS = 8192,
   parameter int KBD_ADDR     = 24576,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] addressM,
   input  logic [15:0] outM,
   input  logic        writeM,
   output logic [15:0] inM,
   input  logic        key_valid,
   input  logic [15:0] key_code,
   output logic        fb_valid,
   input  logic        fb_ready,
   output logic [12:0] fb_addr,
   output logic [15:0] fb_data,
   output logic        fifo_overflow
);

   import hack_mem_pkg::*;

   localparam int          RAM_AW  = $clog2(RAM_WORDS);
   localparam int          SCR_AW  = $clog2(SCREEN_WORDS);
   localparam logic [14:0] RAM_TOP = 15'(RAM_WORDS);
   localparam logic [14:0] SCR_TOP = 15'(SCREEN_BASE + 15'(SCREEN_WORDS));
   localparam logic [14:0] KBD_A   = 15'(KBD_ADDR);

   region_t           region;
   region_t           region_q;
   logic [RAM_AW-1:0] ram_idx;
   logic [SCR_AW-1:0] scr_idx;
   logic [15:0]       ram_rd;
   logic [15:0]       scr_rd;
   logic [15:0]       kbd;
   logic [15:0]       kbd_rd;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic              ovf_pulse;

   logic [15:0] ram [RAM_WORDS];
   logic [15:0] scr [SCREEN_WORDS];

   // ---------------- address decode ----------------
   always_comb begin
      if (addressM < RAM_TOP)
         region = REG_RAM;
      else if (addressM >= SCREEN_BASE && addressM < SCR_TOP)
         region = REG_SCREEN;
      else if (addressM == KBD_A)
         region = REG_KBD;
      else
         region = REG_NONE;
   end

   assign ram_idx = addressM[RAM_AW-1:0];
   assign scr_idx = SCR_AW'(addressM - SCREEN_BASE);

   // ---------------- RAMs: single port, registered read ----------------
   // Read and write share the edge, so a colliding read sees the old word.
   always_ff @(posedge clk) begin
      if (!reset && writeM && region == REG_RAM) ram[ram_idx] <= outM;
      ram_rd <= ram[ram_idx];
   end

   always_ff @(posedge clk) begin
      if (!reset && writeM && region == REG_SCREEN) scr[scr_idx] <= outM;
      scr_rd <= scr[scr_idx];
   end

   // ---------------- keyboard, region pipe, sticky overflow ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         kbd           <= '0;
         kbd_rd        <= '0;
         region_q      <= REG_NONE;  // forces inM to 0 for a read caught by reset
         fifo_overflow <= 1'b0;
      end else begin
         if (key_valid) kbd <= key_code;
         kbd_rd   <= kbd;             // pre-update value: same-cycle key load is not seen
         region_q <= region;
         if (ovf_pulse) fifo_overflow <= 1'b1;
      end
   end

   // The region travels with the read, so inM only ever selects one source.
   always_comb begin
      case (region_q)
         REG_RAM:    inM = ram_rd;
         REG_SCREEN: inM = scr_rd;
         REG_KBD:    inM = kbd_rd;
         default:    inM = '0;
      endcase
   end

   // ---------------- screen update queue ----------------
   assign fifo_push = writeM && region == REG_SCREEN;
   assign fifo_pop  = fb_valid && fb_ready;
   assign fb_valid  = !fifo_empty;

   sync_fifo #(
      .WIDTH (29),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk            (clk),
      .reset          (reset),
      .push           (fifo_push),
      .pop            (fifo_pop),
      .din            ({13'(scr_idx), outM}),
      .dout           ({fb_addr, fb_data}),
      .empty          (fifo_empty),
      .full           (fifo_full),
      .overflow_pulse (ovf_pulse)
   );

endmodule

// File: tb/tb_data_memory_controller.sv
module tb_data_memory_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic        key_valid;
   logic [15:0] key_code;
   logic        fb_valid;
   logic        fb_ready;
   logic [12:0] fb_addr;
   logic [15:0] fb_data;
   logic        fifo_overflow;

   data_memory_controller #(
      .RAM_WORDS    (16384),
      .SCREEN_WORDS (8192),
      .KBD_ADDR     (24576),
      .FIFO_DEPTH   (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .addressM      (addressM),
      .outM          (outM),
      .writeM        (writeM),
      .inM           (inM),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .fb_valid      (fb_valid),
      .fb_ready      (fb_ready),
      .fb_addr       (fb_addr),
      .fb_data       (fb_data),
      .fifo_overflow (fifo_overflow)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] exp_rd_q [$];
   logic [28:0] exp_fb_q [$];
   logic        rd_req      = 1'b0;
   logic        rd_inflight = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // A read presented at one edge must show on inM before the next edge.
   always @(posedge clk) rd_inflight <= rd_req;

   // Monitor: compares DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      if (rd_inflight) begin
         if (exp_rd_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rd_unexpected: inM=0x%0h with no expected read", inM);
         end else begin
            check("inM", {16'h0, inM}, {16'h0, exp_rd_q.pop_front()});
         end
      end
      if (fb_valid && fb_ready) begin
         if (exp_fb_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL fb_unexpected: event addr=0x%0h data=0x%0h", fb_addr, fb_data);
         end else begin
            check("fb_event", {3'b0, fb_addr, fb_data}, {3'b0, exp_fb_q.pop_front()});
         end
      end
   end

   // Present one cycle of CPU stimulus; exp is the inM value due one cycle later.
   task automatic drive(input logic [14:0] a, input logic [15:0] d, input logic we,
                        input logic rd, input logic [15:0] exp);
      @(posedge clk); #1;
      addressM  = a;
      outM      = d;
      writeM    = we;
      rd_req    = rd;
      key_valid = 1'b0;
      if (rd) exp_rd_q.push_back(exp);
   endtask

   task automatic idle();
      drive(15'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; addressM = 15'h7FFF; outM = '0; writeM = 1'b0;
      key_valid = 1'b0; key_code = '0; fb_ready = 1'b0;

      // ---- reset state ----
      idle(); idle();
      @(negedge clk);
      check("rst_inM",      {16'h0, inM},     32'h0);
      check("rst_fb_valid", {31'h0, fb_valid}, 32'h0);
      check("rst_fb_addr",  {19'h0, fb_addr}, 32'h0);
      check("rst_fb_data",  {16'h0, fb_data}, 32'h0);
      check("rst_overflow", {31'h0, fifo_overflow}, 32'h0);
      idle(); reset = 1'b0;

      // ---- 1: RAM write then read, one-cycle latency ----
      drive(15'h0010, 16'h1234, 1'b1, 1'b0, 16'h0);
      drive(15'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234);
      // RAM upper boundary; must not generate a screen event
      drive(15'h3FFF, 16'hBEEF, 1'b1, 1'b0, 16'h0);
      drive(15'h3FFF, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
      idle();
      @(negedge clk);
      check("ram_wr_no_event", {31'h0, fb_valid}, 32'h0);

      // ---- 2: single screen event, held under backpressure ----
      drive(15'h4005, 16'hFFFF, 1'b1, 1'b0, 16'h0);
      exp_fb_q.push_back({13'h0005, 16'hFFFF});
      @(negedge clk);
      check("fb_no_bypass", {31'h0, fb_valid}, 32'h0);
      idle();
      @(negedge clk);
      check("fb_valid_rise", {31'h0, fb_valid}, 32'h1);
      check("fb_addr",       {19'h0, fb_addr}, 32'h0005);
      check("fb_data",       {16'h0, fb_data}, 32'hFFFF);
      idle();
      @(negedge clk);
      check("fb_hold_valid", {31'h0, fb_valid}, 32'h1);
      check("fb_hold_addr",  {19'h0, fb_addr}, 32'h0005);
      check("fb_hold_data",  {16'h0, fb_data}, 32'hFFFF);
      idle(); fb_ready = 1'b1;
      idle(); fb_ready = 1'b0;
      @(negedge clk);
      check("fb_valid_after_pop", {31'h0, fb_valid}, 32'h0);

      // ---- 3: overflow on the 17th write, drain exactly 16 ----
      for (int i = 0; i < 17; i++) begin
         drive(15'h4100 + 15'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, 16'h0);
         if (i < 16) exp_fb_q.push_back({13'h0100 + 13'(i), 16'hA000 + 16'(i)});
         if (i == 16) begin
            @(negedge clk);
            check("ovf_before_drop", {31'h0, fifo_overflow}, 32'h0);
         end
      end
      idle();
      @(negedge clk);
      check("ovf_after_drop", {31'h0, fifo_overflow}, 32'h1);
      drive(15'h4110, 16'h0000, 1'b0, 1'b1, 16'hA010);
      idle(); fb_ready = 1'b1;
      for (int k = 0; k < 15; k++) idle();
      idle(); fb_ready = 1'b0;
      @(negedge clk);
      check("drain_16_empty", {31'h0, fb_valid}, 32'h0);
      check("ovf_sticky",     {31'h0, fifo_overflow}, 32'h1);

      // ---- 4: full FIFO, push with simultaneous pop ----
      idle(); reset = 1'b1;
      idle(); reset = 1'b0;
      @(negedge clk);
      check("ovf_cleared", {31'h0, fifo_overflow}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         drive(15'h5000 + 15'(i), 16'hC000 + 16'(i), 1'b1, 1'b0, 16'h0);
         exp_fb_q.push_back({13'h1000 + 13'(i), 16'hC000 + 16'(i)});
      end
      drive(15'h5FFF, 16'h1111, 1'b1, 1'b0, 16'h0);
      fb_ready = 1'b1;
      exp_fb_q.push_back({13'h1FFF, 16'h1111});
      idle(); fb_ready = 1'b0;
      @(negedge clk);
      check("full_push_pop_no_ovf", {31'h0, fifo_overflow}, 32'h0);
      check("full_still_valid",     {31'h0, fb_valid}, 32'h1);
      drive(15'h5FFF, 16'h0000, 1'b0, 1'b1, 16'h1111);
      fb_ready = 1'b1;
      for (int k = 0; k < 15; k++) idle();
      idle(); fb_ready = 1'b0;
      @(negedge clk);
      check("occupancy_16_empty", {31'h0, fb_valid}, 32'h0);

      // ---- 5: keyboard register ----
      drive(15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0000);
      key_valid = 1'b1; key_code = 16'h0083;
      drive(15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0083);
      key_code = 16'h0000;
      drive(15'h6000, 16'h5555, 1'b1, 1'b1, 16'h0083);
      drive(15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0083);
      drive(15'h6001, 16'h7777, 1'b1, 1'b1, 16'h0000);
      drive(15'h6001, 16'h0000, 1'b0, 1'b1, 16'h0000);
      drive(15'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h0000);
      idle();
      @(negedge clk);
      check("unmapped_no_event", {31'h0, fb_valid}, 32'h0);

      // ---- 6: read-before-write, then reset with events pending ----
      drive(15'h0020, 16'hAAAA, 1'b1, 1'b0, 16'h0);
      drive(15'h0020, 16'hBBBB, 1'b1, 1'b1, 16'hAAAA);
      drive(15'h0020, 16'h0000, 1'b0, 1'b1, 16'hBBBB);
      for (int i = 0; i < 3; i++)
         drive(15'h4001 + 15'(i), 16'h0100 + 16'(i), 1'b1, 1'b0, 16'h0);
      drive(15'h0020, 16'h0000, 1'b0, 1'b1, 16'h0000);
      reset = 1'b1;
      idle(); reset = 1'b0;
      @(negedge clk);
      check("mid_rst_fb_valid", {31'h0, fb_valid}, 32'h0);
      check("mid_rst_fb_addr",  {19'h0, fb_addr}, 32'h0);
      check("mid_rst_overflow", {31'h0, fifo_overflow}, 32'h0);
      drive(15'h0020, 16'h0000, 1'b0, 1'b1, 16'hBBBB);
      idle(); idle();
      @(negedge clk);
      check("post_rst_fb_valid", {31'h0, fb_valid}, 32'h0);

      check("rd_queue_drained", exp_rd_q.size(), 32'h0);
      check("fb_queue_drained", exp_fb_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
